// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and the exec operand mux.
package rv_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MC_BUSY  = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_HALT     = 2'd3
   } pipe_state_t;

   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_MEM  = 2'd1;
   localparam logic [1:0] FWD_WB   = 2'd2;

   // Younger (mem) result wins over older (wb); x0 is hardwired and never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] mem_rd, input logic mem_we,
                                          input logic [4:0] wb_rd, input logic wb_we);
      if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
         return FWD_MEM;
      end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
         return FWD_WB;
      end
      return FWD_NONE;
   endfunction

endpackage

// File: rtl/rv_fwd_unit.sv
// Combinational operand-forwarding selects for both exec ALU operands.
module rv_fwd_unit
   import rv_ctrl_pkg::*;
(
   input  logic [4:0] i_ex_rs1,
   input  logic [4:0] i_ex_rs2,
   input  logic [4:0] i_mem_rd,
   input  logic       i_mem_reg_write,
   input  logic [4:0] i_wb_rd,
   input  logic       i_wb_reg_write,
   output logic [1:0] o_fwd_a,
   output logic [1:0] o_fwd_b
);

   always_comb begin
      o_fwd_a = fwd_sel(i_ex_rs1, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);
      o_fwd_b = fwd_sel(i_ex_rs2, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);
   end

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Pipeline sequencer: stall/flush control, multi-cycle op sequencing, data-bus
// timeout halt and stall-cycle counter.
module rv_pipe_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_dec_valid,
   input  logic [4:0]  i_dec_rs1,
   input  logic [4:0]  i_dec_rs2,
   input  logic [4:0]  i_ex_rs1,
   input  logic [4:0]  i_ex_rs2,
   input  logic [4:0]  i_ex_rd,
   input  logic        i_ex_mem_read,
   input  logic        i_ex_pc_src,
   input  logic        i_ex_mc,
   input  logic        i_mc_done,
   input  logic [4:0]  i_mem_rd,
   input  logic        i_mem_reg_write,
   input  logic [4:0]  i_wb_rd,
   input  logic        i_wb_reg_write,
   input  logic        i_mem_req,
   input  logic        i_mem_ack,
   output logic        o_stall_if,
   output logic        o_stall_id,
   output logic        o_stall_ex,
   output logic        o_stall_mem,
   output logic        o_flush_id,
   output logic        o_flush_ex,
   output logic        o_flush_mem,
   output logic        o_mc_start,
   output logic [1:0]  o_fwd_a,
   output logic [1:0]  o_fwd_b,
   output logic        o_halted,
   output logic [31:0] o_stall_cycles
);

   localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

   pipe_state_t   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic [31:0]   stall_cnt_q, stall_cnt_d;
   logic          eval_run, wait_ok, load_use;

   rv_fwd_unit u_fwd (
      .i_ex_rs1        (i_ex_rs1),
      .i_ex_rs2        (i_ex_rs2),
      .i_mem_rd        (i_mem_rd),
      .i_mem_reg_write (i_mem_reg_write),
      .i_wb_rd         (i_wb_rd),
      .i_wb_reg_write  (i_wb_reg_write),
      .o_fwd_a         (o_fwd_a),
      .o_fwd_b         (o_fwd_b)
   );

   assign load_use  = i_ex_mem_read && (i_ex_rd != 5'd0) && i_dec_valid &&
                      ((i_ex_rd == i_dec_rs1) || (i_ex_rd == i_dec_rs2));
   // Compared after increment so the halt decision lands on the MEM_TIMEOUT-th
   // wait cycle, counting the RUN cycle that first saw the un-acked request.
   assign timer_inc = timer_q + TW'(1);

   always_comb begin
      o_stall_if  = 1'b0;
      o_stall_id  = 1'b0;
      o_stall_ex  = 1'b0;
      o_stall_mem = 1'b0;
      o_flush_id  = 1'b0;
      o_flush_ex  = 1'b0;
      o_flush_mem = 1'b0;
      o_mc_start  = 1'b0;
      state_d     = state_q;
      timer_d     = timer_q;
      eval_run    = 1'b0;
      wait_ok     = 1'b0;

      unique case (state_q)
         S_RUN: begin
            eval_run = 1'b1;
            wait_ok  = 1'b1;
         end
         S_MC_BUSY: begin
            if (i_mc_done) begin
               state_d = S_RUN;
            end else begin
               o_stall_if  = 1'b1;
               o_stall_id  = 1'b1;
               o_stall_ex  = 1'b1;
               o_flush_mem = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (i_mem_ack) begin
               eval_run = 1'b1;
            end else begin
               o_stall_if  = 1'b1;
               o_stall_id  = 1'b1;
               o_stall_ex  = 1'b1;
               o_stall_mem = 1'b1;
               timer_d     = timer_inc;
               if (timer_inc == TIMER_LAST) begin
                  state_d = S_HALT;
               end
            end
         end
         S_HALT: begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
         end
      endcase

      // Shared RUN priority chain; on the ack cycle of a wait the bus rule is masked.
      if (eval_run) begin
         state_d = S_RUN;
         if (wait_ok && i_mem_req && !i_mem_ack) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
            state_d     = S_MEM_WAIT;
            timer_d     = '0;
         end else if (i_ex_mc) begin
            o_mc_start  = 1'b1;
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_flush_mem = 1'b1;
            state_d     = S_MC_BUSY;
         end else if (i_ex_pc_src) begin
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
         end else if (load_use) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_flush_ex = 1'b1;
         end
      end
   end

   assign stall_cnt_d = o_stall_if ? (stall_cnt_q + 32'd1) : stall_cnt_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_RUN;
         timer_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_halted       = (state_q == S_HALT);
   assign o_stall_cycles = stall_cnt_q;

endmodule
